// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default widths, bias helper, canonical
// single-precision constants, operand classes, exception flags, divider states.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;

  localparam logic [31:0] SP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] SP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] SP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int unsigned FLG_W  = 5;
  localparam int unsigned FLG_NX = 0;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_NV = 4;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPEC,
    ST_DIV,
    ST_RND,
    ST_DONE
  } div_state_e;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq.
// out_flags exists only when FP_DIV_FLAGS_EN is defined.
interface fp_div_seq_if
  import fp_pkg::*;
#(
  parameter int unsigned W = 1 + DEF_EXP_W + DEF_MAN_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
`ifdef FP_DIV_FLAGS_EN
  logic [FLG_W-1:0] out_flags;
`endif

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q
`ifdef FP_DIV_FLAGS_EN
    , input out_flags
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q
`ifdef FP_DIV_FLAGS_EN
    , output out_flags
`endif
  );
endinterface

// File: rtl/fp_classify.sv
// Combinational operand splitter/classifier; denormals are reported as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] word,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W-1:0]     frac,
  output fp_class_e            cls
);
  assign sign = word[EXP_W+MAN_W];
  assign expo = word[EXP_W+MAN_W-1 -: EXP_W];
  assign frac = word[MAN_W-1:0];

  always_comb begin
    cls = CLS_NORM;
    if (expo == '1)      cls = (frac != '0) ? CLS_NAN : CLS_INF;
    else if (expo == '0) cls = CLS_ZERO;
  end
endmodule

// File: rtl/fp_div_seq.sv
// Iterative radix-2 restoring IEEE-754 divider, RNE rounding, one op in flight.
// Define FP_DIV_FLAGS_EN to build the exception flag output.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input logic         clk,
  input logic         rst,
  fp_div_seq_if.slave bus
);
  localparam int unsigned W       = 1 + EXP_W + MAN_W;
  localparam int unsigned QW      = MAN_W + 4;
  localparam int unsigned RW      = MAN_W + 2;
  localparam int unsigned EW      = EXP_W + 2;
  localparam int unsigned CNT_W   = $clog2(MAN_W + 5);
  localparam int unsigned BIAS    = fp_bias(EXP_W);
  localparam int unsigned EXP_MAX = (32'd1 << EXP_W) - 32'd1;
  localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] MAG_INF = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;
  fp_class_e        cls_a_r, cls_b_r;
  logic [EW-1:0]    exp_r;
  logic [MAN_W:0]   mb_r;
  logic [RW-1:0]    rem_r;
  logic [QW-1:0]    quo_r;
  logic [W-1:0]     q_r;
  logic             valid_r, ready_r;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .word(bus.in_a), .sign(sa), .expo(ea), .frac(fa), .cls(ca)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .word(bus.in_b), .sign(sb), .expo(eb), .frac(fb), .cls(cb)
  );

  logic accept, spec_fin;
  assign accept   = (state == ST_IDLE) && bus.in_valid;
  assign spec_fin = (state == ST_SPEC) && (cnt != '0);

  // One restoring step: trial subtract, keep on success, shift left
  logic          rem_ge;
  logic [RW-1:0] rem_sub, rem_nxt;
  always_comb begin
    rem_ge  = rem_r >= RW'(mb_r);
    rem_sub = rem_ge ? (rem_r - RW'(mb_r)) : rem_r;
    rem_nxt = {rem_sub[RW-2:0], 1'b0};
  end

  // Special-operand result, resolved from the registered classes
  logic          spec_nan;
  logic [W-1:0]  spec_q;
  always_comb begin
    spec_nan = (cls_a_r == CLS_NAN) || (cls_b_r == CLS_NAN) ||
               ((cls_a_r == cls_b_r) && ((cls_a_r == CLS_ZERO) || (cls_a_r == CLS_INF)));
    spec_q   = {sign_r, {(W-1){1'b0}}};
    if (spec_nan)                                        spec_q = QNAN;
    else if ((cls_a_r == CLS_INF) || (cls_b_r == CLS_ZERO)) spec_q = {sign_r, MAG_INF};
  end

  // Normalise, round to nearest even, then range-check the exponent
  logic [MAN_W-1:0] mant, frac_fin;
  logic             g, r, s, rup, rnd_of, rnd_uf;
  logic [MAN_W+1:0] mr;
  logic [EW-1:0]    e_norm, e_fin;
  logic [W-1:0]     rnd_q;
  always_comb begin
    mant   = quo_r[QW-3:2];
    g      = quo_r[1];
    r      = quo_r[0];
    s      = (rem_r != '0);
    e_norm = exp_r - EW'(1);
    if (quo_r[QW-1]) begin
      mant   = quo_r[QW-2:3];
      g      = quo_r[2];
      r      = quo_r[1];
      s      = quo_r[0] | (rem_r != '0);
      e_norm = exp_r;
    end
    rup      = g & (r | s | mant[0]);
    mr       = {2'b01, mant} + (MAN_W+2)'(rup);
    frac_fin = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    e_fin    = mr[MAN_W+1] ? (e_norm + EW'(1)) : e_norm;
    rnd_of   = !e_fin[EW-1] && (e_fin >= EW'(EXP_MAX));
    rnd_uf   = e_fin[EW-1] || (e_fin == '0);
    rnd_q    = {sign_r, e_fin[EXP_W-1:0], frac_fin};
    if (rnd_of)      rnd_q = {sign_r, MAG_INF};
    else if (rnd_uf) rnd_q = {sign_r, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      q_r     <= '0;
      sign_r  <= 1'b0;
      cls_a_r <= CLS_ZERO;
      cls_b_r <= CLS_ZERO;
      exp_r   <= '0;
      mb_r    <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          ready_r <= 1'b0;
          cnt     <= '0;
          sign_r  <= sa ^ sb;
          cls_a_r <= ca;
          cls_b_r <= cb;
          exp_r   <= EW'(ea) - EW'(eb) + EW'(BIAS);
          mb_r    <= {1'b1, fb};
          rem_r   <= RW'({1'b1, fa});
          quo_r   <= '0;
          state   <= ((ca == CLS_NORM) && (cb == CLS_NORM)) ? ST_DIV : ST_SPEC;
        end
        // Specials take two cycles so their latency stays fixed and short
        ST_SPEC: begin
          if (cnt == '0) begin
            cnt <= CNT_W'(1);
          end else begin
            q_r     <= spec_q;
            valid_r <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DIV: begin
          rem_r <= rem_nxt;
          quo_r <= {quo_r[QW-2:0], rem_ge};
          if (cnt == CNT_W'(QW - 1)) state <= ST_RND;
          else                       cnt   <= cnt + CNT_W'(1);
        end
        ST_RND: begin
          q_r     <= rnd_q;
          valid_r <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.out_valid = valid_r;
  assign bus.out_q     = q_r;

`ifdef FP_DIV_FLAGS_EN
  fp_flags_t flags_r, spec_flags, rnd_flags;
  always_comb begin
    spec_flags             = '0;
    spec_flags.invalid     = spec_nan;
    spec_flags.div_by_zero = !spec_nan && (cls_a_r != CLS_INF) && (cls_b_r == CLS_ZERO);
    rnd_flags              = '0;
    rnd_flags.overflow     = rnd_of;
    rnd_flags.underflow    = rnd_uf;
    rnd_flags.inexact      = g | r | s | rnd_of | rnd_uf;
  end

  always_ff @(posedge clk) begin
    if (rst || accept)        flags_r <= '0;
    else if (spec_fin)        flags_r <= spec_flags;
    else if (state == ST_RND) flags_r <= rnd_flags;
  end

  assign bus.out_flags = flags_r;
`endif
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq (single precision).
// Flag checks are compiled in when FP_DIV_FLAGS_EN is defined.
module tb_fp_div_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_div_seq_if #(.W(32)) bus ();

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q_exp, input logic [4:0] f_exp, input int lat_exp);
    int lat;
    send(a, b);
    wait_out(lat);
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_q"}, bus.out_q, q_exp);
`ifdef FP_DIV_FLAGS_EN
    check({tag, "_flags"}, 32'(bus.out_flags), 32'(f_exp));
`endif
    take();
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [31:0] b2b_a [4];
  logic [31:0] b2b_b [4];
  logic [31:0] b2b_q [4];

  initial begin
    int          lat;
    logic [31:0] held;
    logic        saw_valid;
    logic        accepting;
    int          k_in;
    int          k_out;

    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_q", bus.out_q, 32'h0);
`ifdef FP_DIV_FLAGS_EN
    check("reset_flags", 32'(bus.out_flags), 32'd0);
`endif

    // Normal operands: flags are {invalid, dz, overflow, underflow, inexact}
    run_op("div_116_3",    32'h42E80000, 32'h40400000, 32'h421AAAAB, 5'b00001, 28);
    run_op("div_116_m3",   32'h42E80000, 32'hC0400000, 32'hC21AAAAB, 5'b00001, 28);
    run_op("div_self",     32'h3F30A3D7, 32'h3F30A3D7, 32'h3F800000, 5'b00000, 28);
    run_op("div_neg_self", 32'hC2E80000, 32'hC2E80000, 32'h3F800000, 5'b00000, 28);

    // Special operands
    run_op("x_div_mzero",  32'h3F30A3D7, 32'h80000000, 32'hFF800000, 5'b01000, 2);
    run_op("zero_div_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2);
    run_op("inf_div_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2);
    run_op("nan_div_one",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2);
    run_op("inf_div_m3",   32'h7F800000, 32'hC0400000, 32'hFF800000, 5'b00000, 2);
    run_op("x_div_inf",    32'h3F30A3D7, 32'h7F800000, 32'h00000000, 5'b00000, 2);

    // Range limits
    run_op("overflow",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);

    // Back-pressure: result must hold while the consumer stalls
    send(32'h42E80000, 32'h40400000);
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'd28);
    held = bus.out_q;
    check("bp_q", held, 32'h421AAAAB);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_q_stable", bus.out_q, held);
      check("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    take();
    check("bp_ready_after_pulse", 32'(bus.in_ready), 32'd1);
    check("bp_valid_dropped", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of the iteration loop
    send(32'h42E80000, 32'h40400000);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_output", 32'(saw_valid), 32'd0);
    run_op("after_rst", 32'h3F30A3D7, 32'h3F30A3D7, 32'h3F800000, 5'b00000, 28);

    // Back-to-back with in_valid held high and consumer always ready
    b2b_a[0] = 32'h42E80000; b2b_b[0] = 32'h40400000; b2b_q[0] = 32'h421AAAAB;
    b2b_a[1] = 32'h42E80000; b2b_b[1] = 32'hC0400000; b2b_q[1] = 32'hC21AAAAB;
    b2b_a[2] = 32'h3F30A3D7; b2b_b[2] = 32'h3F30A3D7; b2b_q[2] = 32'h3F800000;
    b2b_a[3] = 32'h7F800000; b2b_b[3] = 32'hC0400000; b2b_q[3] = 32'hFF800000;
    k_in          = 0;
    k_out         = 0;
    bus.out_ready = 1'b1;
    bus.in_a      = b2b_a[0];
    bus.in_b      = b2b_b[0];
    bus.in_valid  = 1'b1;
    for (int cyc = 0; cyc < 400 && k_out < 4; cyc++) begin
      accepting = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        check("b2b_q", bus.out_q, b2b_q[k_out]);
        check("b2b_no_overlap", 32'(bus.in_ready), 32'd0);
        k_out++;
      end
      @(posedge clk); #1;
      if (accepting) begin
        k_in++;
        if (k_in < 4) begin
          bus.in_a = b2b_a[k_in];
          bus.in_b = b2b_b[k_in];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_results", 32'(k_out), 32'd4);
    check("b2b_accepts", 32'(k_in), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
